rpn_exec: RTL
=============

RPN_EXEC -- requirements
Module: rpn_exec

Interface
REQ-001 SHALL have parameter DEPTH_MAX, default 31: the maximum number of entries it tracks in the downstream stack/queue memory.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port op_valid, input, 1 bit: an operation request is present.
REQ-005 SHALL have port op_ready, output, 1 bit: the block can accept an operation.
REQ-006 SHALL have port opcode, input, 3 bits: the operation code.
REQ-007 SHALL have port op_mode, input, 1 bit: operand order, 0 = stack, 1 = queue.
REQ-008 SHALL have port imm, input, 32 bits: the literal for PUSHI.
REQ-009 SHALL have ports mem_push, mem_pop and mem_sq, each an output of 1 bit, as the command strobes to the memory.
REQ-010 SHALL have port mem_wdata, output, 32 bits: the data pushed to the memory.
REQ-011 SHALL have ports mem_stack_rd and mem_queue_rd, each an input of 32 bits: the memory's top and base outputs.
REQ-012 SHALL have port result, output, 32 bits: the last computed or pushed value.
REQ-013 SHALL have port result_valid, output, 1 bit: a one-cycle pulse marking result.
REQ-014 SHALL have port err, output, 1 bit: a one-cycle error pulse.
REQ-015 SHALL have port err_code, output, 2 bits: 01 = underflow, 10 = overflow, 11 = illegal opcode.
REQ-016 SHALL have port depth, output, 5 bits: the tracked entry count.

Function
REQ-017 SHALL decode the opcodes as: 000 NOP, 001 PUSHI, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR, 111 MUL.
REQ-018 SHALL use an FSM with states IDLE, RD_A, RD_B, EXEC, WR and ERR.
REQ-019 SHALL assert op_ready only in IDLE, and SHALL accept an operation on a clock edge where op_valid and op_ready are both high.
REQ-020 SHALL latch opcode, op_mode and imm on acceptance.
REQ-021 SHALL complete a NOP in IDLE with no memory strobes and no result_valid.
REQ-022 SHALL take PUSHI to WR if depth < DEPTH_MAX, and to ERR with code 10 otherwise.
REQ-023 SHALL take a binary operation to RD_A if depth >= 2, and to ERR with code 01 otherwise.
REQ-024 SHALL, in RD_A, sample operand A from mem_stack_rd (mode 0) or mem_queue_rd (mode 1), and pulse mem_pop with mem_sq = mode.
REQ-025 SHALL, in RD_B, sample operand B from the same selected input and pulse mem_pop again.
REQ-026 SHALL, in EXEC, compute result as B op A in stack mode and as A op B in queue mode.
REQ-027 SHALL apply the ordering of REQ-026 to SUB, so the result is the earlier-pushed value minus the later-pushed value.
REQ-028 SHALL wrap all arithmetic modulo 2^32, and SHALL keep the low 32 bits of a MUL product.
REQ-029 SHALL, in WR, pulse mem_push for one cycle with mem_wdata = result, pulse result_valid, and return to IDLE.
REQ-030 SHALL, in ERR, pulse err for one cycle with err_code set, issue no memory strobes, and return to IDLE.
REQ-031 SHALL never assert mem_push and mem_pop in the same cycle.
REQ-032 SHALL update depth by +1 per mem_push and -1 per mem_pop, saturating at 0 and DEPTH_MAX.
REQ-033 SHALL give a binary operation a latency of 4 cycles from acceptance to result_valid (RD_A, RD_B, EXEC, WR), and PUSHI a latency of 1 cycle.
REQ-034 SHALL leave err_code unchanged until the next error.

Reset
REQ-035 SHALL, while rst is low, asynchronously force IDLE, all strobes 0, result 0, depth 0, err 0, err_code 00 and result_valid 0.
REQ-036 SHALL let a reset asserted mid-operation abandon the operation with no further strobes, consistent with the memory resetting on the same rst.
REQ-037 SHALL drive op_ready = 1 on the first clock after rst is released.

Configuration
REQ-038 SHALL compile the MUL datapath into the block when macro RPN_MUL_EN is defined, and SHALL execute opcode 111 as a normal binary operation in that case.
REQ-039 SHALL compile no multiplier when RPN_MUL_EN is undefined, and SHALL then send opcode 111 to ERR with code 11 and leave depth unchanged.

Structure
REQ-040 SHALL take the opcode constants, FSM state encodings, err_code constants and the 32-bit data width from the shared package rpn_pkg.
REQ-041 SHALL place the combinational datapath (ADD/SUB/AND/OR/XOR/optional MUL) in a sub-module rpn_alu; the FSM, depth counter and handshake stay in rpn_exec.

Verification
REQ-042 SHALL be verified by: reset, then PUSHI 5, PUSHI 3, SUB (stack) -> mem_push with 2, depth 1, result_valid exactly 4 cycles after SUB is accepted.
REQ-043 SHALL be verified by: PUSHI 5, PUSHI 3, SUB (queue) -> result 2, mem_sq = 1 on both pops.
REQ-044 SHALL be verified by: ADD 0xFFFFFFFF + 1 -> result 0, with no error.
REQ-045 SHALL be verified by: ADD issued with depth 1 -> err = 1, err_code 01, no strobes, depth stays 1.
REQ-046 SHALL be verified by: 31 PUSHIs followed by a 32nd PUSHI -> err_code 10 and depth stays 31.
REQ-047 SHALL be verified by: opcode 111 with 6 and 7 -> result 42 when RPN_MUL_EN is defined, err_code 11 when it is not; and rst pulsed during RD_B -> IDLE, depth 0.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared constants for the RPN executor: data width, opcodes, FSM states, error codes.
package rpn_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_PUSHI = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_AND   = 3'b100,
    OP_OR    = 3'b101,
    OP_XOR   = 3'b110,
    OP_MUL   = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXEC = 3'd3,
    S_WR   = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_UNDERFLOW = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL   = 2'b11;

endpackage

// File: rtl/rpn_alu.sv
// Combinational datapath computing lhs op rhs; the multiplier exists only when RPN_MUL_EN is defined.
module rpn_alu
  import rpn_pkg::*;
(
  input  logic [2:0]        opcode,
  input  logic [DATA_W-1:0] lhs,
  input  logic [DATA_W-1:0] rhs,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (opcode)
      OP_ADD: y = lhs + rhs;
      OP_SUB: y = lhs - rhs;
      OP_AND: y = lhs & rhs;
      OP_OR:  y = lhs | rhs;
      OP_XOR: y = lhs ^ rhs;
`ifdef RPN_MUL_EN
      // 32-bit context keeps only the low word of the product.
      OP_MUL: y = lhs * rhs;
`endif
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rpn_exec.sv
// RPN executor: accepts one operation at a time, pops operands from an external stack/queue
// memory, evaluates them in rpn_alu and pushes the result back. MUL requires RPN_MUL_EN.
module rpn_exec
  import rpn_pkg::*;
#(
  parameter int DEPTH_MAX = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        opcode,
  input  logic              op_mode,
  input  logic [DATA_W-1:0] imm,
  output logic              mem_push,
  output logic              mem_pop,
  output logic              mem_sq,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_stack_rd,
  input  logic [DATA_W-1:0] mem_queue_rd,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [4:0]        depth,
  output logic [2:0]        state_dbg
);

  localparam logic [4:0] DMAX = 5'(DEPTH_MAX);

  // Handshake: an operation transfers on a rising edge where op_valid and op_ready are both high;
  // op_ready is high only in IDLE, so at most one operation is in flight.
  state_e            state, state_next;
  logic [2:0]        opc_q;
  logic              mode_q;
  logic [DATA_W-1:0] a_q, b_q, result_q, alu_y, sel_rd, lhs, rhs;
  logic [1:0]        err_code_q, err_code_next;
  logic [4:0]        depth_q;
  logic              accept;

  assign accept    = op_valid && (state == S_IDLE);
  assign sel_rd    = mode_q ? mem_queue_rd : mem_stack_rd;
  // Stack mode pops the later-pushed value first, so B op A restores push order; queue is the reverse.
  assign lhs       = mode_q ? a_q : b_q;
  assign rhs       = mode_q ? b_q : a_q;
  assign result    = result_q;
  assign mem_wdata = result_q;
  assign err_code  = err_code_q;
  assign depth     = depth_q;
  assign state_dbg = state;

  rpn_alu u_alu (
    .opcode (opc_q),
    .lhs    (lhs),
    .rhs    (rhs),
    .y      (alu_y)
  );

  always_comb begin
    state_next    = state;
    err_code_next = err_code_q;
    op_ready      = 1'b0;
    mem_push      = 1'b0;
    mem_pop       = 1'b0;
    mem_sq        = 1'b0;
    result_valid  = 1'b0;
    err           = 1'b0;
    case (state)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          case (opcode)
            OP_NOP: state_next = S_IDLE;
            OP_PUSHI: begin
              if (depth_q < DMAX) state_next = S_WR;
              else begin
                state_next    = S_ERR;
                err_code_next = ERR_OVERFLOW;
              end
            end
`ifndef RPN_MUL_EN
            OP_MUL: begin
              state_next    = S_ERR;
              err_code_next = ERR_ILLEGAL;
            end
`endif
            default: begin
              if (depth_q >= 5'd2) state_next = S_RD_A;
              else begin
                state_next    = S_ERR;
                err_code_next = ERR_UNDERFLOW;
              end
            end
          endcase
        end
      end
      S_RD_A: begin
        mem_pop    = 1'b1;
        mem_sq     = mode_q;
        state_next = S_RD_B;
      end
      S_RD_B: begin
        mem_pop    = 1'b1;
        mem_sq     = mode_q;
        state_next = S_EXEC;
      end
      S_EXEC: state_next = S_WR;
      S_WR: begin
        mem_push     = 1'b1;
        result_valid = 1'b1;
        state_next   = S_IDLE;
      end
      S_ERR: begin
        err        = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      opc_q      <= OP_NOP;
      mode_q     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      err_code_q <= ERR_NONE;
      depth_q    <= '0;
    end else begin
      state      <= state_next;
      err_code_q <= err_code_next;
      if (accept) begin
        opc_q  <= opcode;
        mode_q <= op_mode;
        if (opcode == OP_PUSHI) result_q <= imm;
      end
      if (state == S_RD_A) a_q <= sel_rd;
      if (state == S_RD_B) b_q <= sel_rd;
      if (state == S_EXEC) result_q <= alu_y;
      if (mem_push && depth_q != DMAX) depth_q <= depth_q + 5'd1;
      else if (mem_pop && depth_q != 5'd0) depth_q <= depth_q - 5'd1;
    end
  end

endmodule
